// File: rtl/wb_select_reg.sv
// wb_select_reg: selects one of NSRC DATA_W-bit bus sources, or a fixed
// constant, into a one-entry write-back register with a valid/ready
// handshake on both sides. Latency is one cycle. in_ready is the only
// combinational output.
//
// Optional feature macro WB_SEL_ERR_EN:
//   defined   - an accepted select above NSRC is dropped without touching
//               wb_data/wb_valid, and sets the sticky sel_err flag.
//   undefined - an accepted select above NSRC loads zero; sel_err is
//               constant 0.
module wb_select_reg #(
  parameter int DATA_W    = 32,
  parameter int NSRC      = 8,
  parameter int SEL_W     = 4,
  parameter int CONST_VAL = 227
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SEL_W-1:0]       sel,
  input  logic [NSRC*DATA_W-1:0] src_bus,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      wb_data,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic                   sel_err
);

  // Select index that returns the constant; anything above it is illegal.
  localparam logic [SEL_W-1:0]  CONST_SEL  = SEL_W'(NSRC);
  localparam logic [DATA_W-1:0] CONST_WORD = DATA_W'(CONST_VAL);

  logic              accept;
  logic              consume;
  logic              load_en;
  logic [DATA_W-1:0] load_data;

  // The slot can take new data when it is empty or being drained this cycle.
  assign in_ready = !wb_valid || wb_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = wb_valid && wb_ready;

  // Source decode: legal sources, the constant slot, zero for anything else.
  always_comb begin
    // NOTE: the default assignment first keeps this block free of inferred
    // latches when sel matches no branch.
    load_data = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel == SEL_W'(k)) begin
        load_data = src_bus[k*DATA_W +: DATA_W];
      end
    end
    if (sel == CONST_SEL) begin
      load_data = CONST_WORD;
    end
  end

`ifdef WB_SEL_ERR_EN
  logic sel_illegal;
  logic sel_err_q;

  assign sel_illegal = (sel > CONST_SEL);
  // An illegal select still completes the handshake but never loads.
  assign load_en     = accept && !sel_illegal;
  assign sel_err     = sel_err_q;

  // Sticky error flag: set by any accepted illegal select, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err_q <= 1'b0;
    end else if (accept && sel_illegal) begin
      sel_err_q <= 1'b1;
    end
  end
`else
  // Illegal selects load the zero produced by the decode default.
  assign load_en = accept;
  assign sel_err = 1'b0;
`endif

  // Output register: load on accept, otherwise drop valid once consumed.
  // wb_data keeps its value on consume so a late reader still sees it.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values; reset is synchronous and checked first so it
    // overrides any accept or consume in the same cycle.
    if (reset) begin
      wb_data  <= '0;
      wb_valid <= 1'b0;
    end else if (load_en) begin
      wb_data  <= load_data;
      wb_valid <= 1'b1;
    end else if (consume) begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: doc/wb_select_reg.md
WB_SELECT_REG -- requirements
Module: wb_select_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of each source and of the output in bits.
REQ-002 SHALL have parameter NSRC, default 8, meaning the number of bus sources (legal range 1..15).
REQ-003 SHALL have parameter SEL_W, default 4, meaning the select width; SEL_W SHALL satisfy 2**SEL_W > NSRC.
REQ-004 SHALL have parameter CONST_VAL, default 227, meaning the DATA_W constant returned by select index NSRC.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port sel, input, SEL_W bits: source index for the current transfer.
REQ-008 SHALL have port src_bus, input, NSRC*DATA_W bits: source k occupies bits [k*DATA_W +: DATA_W].
REQ-009 SHALL have port in_valid, input, 1 bit: sel and src_bus carry a transfer request.
REQ-010 SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-011 SHALL have port wb_data, output, DATA_W bits: registered write-back value.
REQ-012 SHALL have port wb_valid, output, 1 bit: wb_data holds an unconsumed value.
REQ-013 SHALL have port wb_ready, input, 1 bit: the consumer takes wb_data this cycle.
REQ-014 SHALL have port sel_err, output, 1 bit: sticky illegal-select flag (see Configuration).

Function
REQ-015 SHALL implement a one-entry output register with valid/ready handshake on both sides.
REQ-016 in_ready SHALL be combinational: in_ready = !wb_valid || wb_ready.
REQ-017 Accept SHALL occur when in_valid && in_ready; accepted data SHALL appear on wb_data with wb_valid=1 on the next cycle, giving one-cycle latency.
REQ-018 Select decode on accept: for sel < NSRC, load source sel; for sel == NSRC, load CONST_VAL; for sel > NSRC, treat as an illegal select.
REQ-019 Consume SHALL occur when wb_valid && wb_ready; if there is no simultaneous accept, wb_valid SHALL clear on the next cycle and wb_data SHALL hold its value.
REQ-020 Simultaneous consume and accept in the same cycle SHALL replace wb_data with the new value, keep wb_valid=1, and lose no data.
REQ-021 While wb_valid=1 and wb_ready=0, wb_data and wb_valid SHALL remain stable regardless of sel, src_bus or in_valid.
REQ-022 sel and src_bus SHALL be sampled only on accept; changes at other times have no effect.
REQ-023 Every output SHALL be registered except in_ready.

Reset
REQ-024 When reset=1 at a clock edge, the block SHALL set wb_data=0, wb_valid=0 and sel_err=0, overriding any accept or consume in that cycle.
REQ-025 While reset=1, in_ready SHALL evaluate to 1 (wb_valid=0 after the first edge) but no transfer SHALL be recorded.
REQ-026 Reset asserted mid-handshake SHALL discard the pending value without producing an output pulse.

Configuration
REQ-027 Feature macro WB_SEL_ERR_EN SHALL control illegal-select handling.
REQ-028 With WB_SEL_ERR_EN defined: an accept with sel > NSRC SHALL be consumed (the handshake completes), SHALL NOT change wb_data or wb_valid, and SHALL set sel_err=1 until reset.
REQ-029 Without WB_SEL_ERR_EN: an accept with sel > NSRC SHALL load 0 into wb_data with wb_valid=1, and sel_err SHALL be tied to 0.

Verification
REQ-030 Reset then in_valid=1, sel=2, source2=0xA5A5_0002, wb_ready=1 -> next cycle wb_data=0xA5A5_0002, wb_valid=1.
REQ-031 sel=8 (NSRC=8), in_valid=1 -> next cycle wb_data=227 (0x0000_00E3), wb_valid=1.
REQ-032 Load 0x11, then hold wb_ready=0 for 3 cycles while presenting sel=1, source1=0x22 -> in_ready=0, wb_data stays 0x11; raise wb_ready -> 0x22 appears the following cycle with no gap in wb_valid.
REQ-033 wb_valid=1, wb_ready=1 and in_valid=1 in the same cycle, new value 0x33 -> wb_data=0x33, wb_valid stays 1.
REQ-034 sel=12 with WB_SEL_ERR_EN defined -> wb_data unchanged, sel_err=1 sticky; with the macro undefined -> wb_data=0, wb_valid=1, sel_err=0.
REQ-035 Assert reset while wb_valid=1 and in_valid=1 -> next cycle wb_data=0, wb_valid=0, sel_err=0.
